// File: rtl/sensor_emu_pkg.sv
// sensor_emu_pkg: mode constants, default parameters and index-width helper for the sensor emulator.
package sensor_emu_pkg;
  localparam int HOLD_PULSE = 0;
  localparam int HOLD_ACK = 1;
  localparam int DEF_NUM_CH = 1;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_PERIOD = 1024;
  localparam int DEF_HOLD = HOLD_PULSE;
  localparam int DEF_WRAP = 1;
  localparam int DEF_OVR_W = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sensor_emu_ch.sv
// sensor_emu_ch: one channel -- sample memory, period counter, replay pointer,
// ready/data presentation, end-of-replay and overrun tracking.
module sensor_emu_ch
  import sensor_emu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PERIOD = DEF_PERIOD,
  parameter int HOLD   = DEF_HOLD,
  parameter int WRAP   = DEF_WRAP,
  parameter int OVR_W  = DEF_OVR_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     ack_i,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [idx_w(DEPTH)-1:0]  addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic                     ready_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     done_o,
  output logic                     ovr_o,
  output logic [OVR_W-1:0]         ovr_cnt_o
);
  localparam int CNT_W = idx_w(PERIOD);
  localparam int PTR_W = idx_w(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic ready_q, ready_d, done_q, done_d, ovr_q, ovr_d;
  logic emit, ovr_ev;

  // Unreset storage; the emission read below sees the pre-write value.
  always_ff @(posedge clk_i)
    if (we_i) mem_q[addr_i] <= wdata_i;

  always_comb begin
    emit = en_i && cnt_q == CNT_W'(PERIOD - 1) && !done_q;
    ovr_ev = HOLD == HOLD_ACK && emit && ready_q && !ack_i;
    cnt_d = (clr_i || emit) ? '0 : (en_i && !done_q) ? cnt_q + 1'b1 : cnt_q;
    ptr_d = clr_i ? '0 : emit ? ptr_q + 1'b1 : ptr_q;
    done_d = !clr_i && (done_q || (WRAP == 0 && emit && ptr_q == PTR_W'(DEPTH - 1)));
    ready_d = clr_i ? 1'b0 : emit ? 1'b1 : (HOLD == HOLD_ACK && ready_q && !ack_i);
    data_d = clr_i ? '0 : emit ? mem_q[ptr_q] : (HOLD == HOLD_ACK) ? data_q : '0;
    ovr_d = !clr_i && (ovr_q || ovr_ev);
    ovr_cnt_d = clr_i ? '0 : (ovr_ev && !(&ovr_cnt_q)) ? ovr_cnt_q + 1'b1 : ovr_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      ptr_q <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      data_q <= data_d;
      ready_q <= ready_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end

  assign ready_o = ready_q;
  assign data_o = data_q;
  assign done_o = done_q;
  assign ovr_o = ovr_q;
  assign ovr_cnt_o = ovr_cnt_q;
endmodule

// File: rtl/sensor_emu.sv
// sensor_emu: multi-channel replaying sensor source; one independent channel
// per NUM_CH with a shared load port decoded by load_ch_i.
module sensor_emu
  import sensor_emu_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PERIOD = DEF_PERIOD,
  parameter int HOLD   = DEF_HOLD,
  parameter int WRAP   = DEF_WRAP,
  parameter int OVR_W  = DEF_OVR_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_CH-1:0]          sensor_en_i,
  input  logic [NUM_CH-1:0]          sensor_ack_i,
  input  logic [NUM_CH-1:0]          sensor_clr_i,
  input  logic                       load_we_i,
  input  logic [idx_w(NUM_CH)-1:0]   load_ch_i,
  input  logic [idx_w(DEPTH)-1:0]    load_addr_i,
  input  logic [DATA_W-1:0]          load_data_i,
  output logic [NUM_CH-1:0]          sensor_ready_o,
  output logic [NUM_CH*DATA_W-1:0]   sensor_out_o,
  output logic [NUM_CH-1:0]          sensor_done_o,
  output logic [NUM_CH-1:0]          sensor_ovr_o,
  output logic [NUM_CH*OVR_W-1:0]    ovr_cnt_o
);
  localparam int CH_W = idx_w(NUM_CH);

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sensor_emu_ch #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .PERIOD(PERIOD),
      .HOLD(HOLD), .WRAP(WRAP), .OVR_W(OVR_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (sensor_en_i[k]),
      .ack_i    (sensor_ack_i[k]),
      .clr_i    (sensor_clr_i[k]),
      .we_i     (load_we_i && load_ch_i == CH_W'(k)),
      .addr_i   (load_addr_i),
      .wdata_i  (load_data_i),
      .ready_o  (sensor_ready_o[k]),
      .data_o   (sensor_out_o[k*DATA_W +: DATA_W]),
      .done_o   (sensor_done_o[k]),
      .ovr_o    (sensor_ovr_o[k]),
      .ovr_cnt_o(ovr_cnt_o[k*OVR_W +: OVR_W])
    );
  end
endmodule

// File: tb/tb_sensor_emu.sv
// tb_sensor_emu: three configurations (2-ch pulse/wrap, 1-ch pulse/no-wrap, 1-ch hold)
// driven with directed vectors; pulse streams are checked by a queue-based monitor.
module tb_sensor_emu;
  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {logic [7:0] d; int t;} exp_t;
  exp_t q0[$], q1[$], q2[$];

  logic [1:0] a_en, a_ack, a_clr, a_rdy, a_done, a_ovr;
  logic a_we, a_ch;
  logic [1:0] a_addr;
  logic [7:0] a_data;
  logic [15:0] a_out;
  logic [3:0] a_oc;

  logic b_en, b_ack, b_clr, b_rdy, b_done, b_ovr, b_we, b_ch;
  logic [1:0] b_addr, b_oc;
  logic [7:0] b_data, b_out;

  logic c_en, c_ack, c_clr, c_rdy, c_done, c_ovr, c_we, c_ch;
  logic [1:0] c_addr, c_oc;
  logic [7:0] c_data, c_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sensor_emu #(.NUM_CH(2), .DATA_W(8), .DEPTH(4), .PERIOD(4), .HOLD(0), .WRAP(1), .OVR_W(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .sensor_en_i(a_en), .sensor_ack_i(a_ack), .sensor_clr_i(a_clr),
    .load_we_i(a_we), .load_ch_i(a_ch), .load_addr_i(a_addr), .load_data_i(a_data),
    .sensor_ready_o(a_rdy), .sensor_out_o(a_out), .sensor_done_o(a_done), .sensor_ovr_o(a_ovr),
    .ovr_cnt_o(a_oc));

  sensor_emu #(.NUM_CH(1), .DATA_W(8), .DEPTH(4), .PERIOD(4), .HOLD(0), .WRAP(0), .OVR_W(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .sensor_en_i(b_en), .sensor_ack_i(b_ack), .sensor_clr_i(b_clr),
    .load_we_i(b_we), .load_ch_i(b_ch), .load_addr_i(b_addr), .load_data_i(b_data),
    .sensor_ready_o(b_rdy), .sensor_out_o(b_out), .sensor_done_o(b_done), .sensor_ovr_o(b_ovr),
    .ovr_cnt_o(b_oc));

  sensor_emu #(.NUM_CH(1), .DATA_W(8), .DEPTH(4), .PERIOD(4), .HOLD(1), .WRAP(1), .OVR_W(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .sensor_en_i(c_en), .sensor_ack_i(c_ack), .sensor_clr_i(c_clr),
    .load_we_i(c_we), .load_ch_i(c_ch), .load_addr_i(c_addr), .load_data_i(c_data),
    .sensor_ready_o(c_rdy), .sensor_out_o(c_out), .sensor_done_o(c_done), .sensor_ovr_o(c_ovr),
    .ovr_cnt_o(c_oc));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cyc=%0d)", nm, got, exp, cyc);
    end
  endtask

  // Pops one expected sample per ready pulse; idle cycles must show zero data.
  task automatic mon(input int s, input logic r, input logic [7:0] d);
    exp_t e;
    logic have;
    have = 1'b0;
    checks++;
    if (r) begin
      case (s)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        fails++;
        $display("FAIL pulse%0d unexpected: got data=%h at cyc=%0d, required no pulse", s, d, cyc);
      end else if (d !== e.d || cyc != e.t) begin
        fails++;
        $display("FAIL pulse%0d: got data=%h at cyc=%0d, required data=%h at cyc=%0d", s, d, cyc, e.d, e.t);
      end
    end else if (d !== 8'h00) begin
      fails++;
      $display("FAIL idle%0d: got out=%h at cyc=%0d, required 00", s, d, cyc);
    end
  endtask

  task automatic load(input int inst, input logic ch, input logic [1:0] ad, input logic [7:0] d);
    case (inst)
      0: begin a_we = 1'b1; a_ch = ch; a_addr = ad; a_data = d; end
      1: begin b_we = 1'b1; b_ch = ch; b_addr = ad; b_data = d; end
      default: begin c_we = 1'b1; c_ch = ch; c_addr = ad; c_data = d; end
    endcase
    step(1);
    a_we = 1'b0;
    b_we = 1'b0;
    c_we = 1'b0;
  endtask

  initial begin
    int c0, c1, c2, c3, c4, r;
    rst_n = 1'b0;
    {a_en, a_ack, a_clr, a_we, a_ch, a_addr, a_data} = '0;
    {b_en, b_ack, b_clr, b_we, b_ch, b_addr, b_data} = '0;
    {c_en, c_ack, c_clr, c_we, c_ch, c_addr, c_data} = '0;
    fork
      forever begin
        @(negedge clk);
        mon(0, a_rdy[0], a_out[7:0]);
        mon(1, a_rdy[1], a_out[15:8]);
        mon(2, b_rdy, b_out);
      end
    join_none
    step(2);
    chk("A ready rst", a_rdy, 0);
    chk("A out rst", a_out, 0);
    chk("A done rst", a_done, 0);
    chk("A ovr rst", a_ovr, 0);
    chk("A ovr_cnt rst", a_oc, 0);
    chk("B done rst", b_done, 0);
    chk("C ready rst", c_rdy, 0);
    chk("C out rst", c_out, 0);
    chk("C ovr rst", c_ovr, 0);
    chk("C ovr_cnt rst", c_oc, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load(0, 1'b0, 2'(i), 8'h0A + 8'(i));
      load(0, 1'b1, 2'(i), 8'h11 * 8'(i + 1));
      load(1, 1'b0, 2'(i), 8'h0A + 8'(i));
      load(2, 1'b0, 2'(i), 8'h0A + 8'(i));
    end
    load(1, 1'b1, 2'd0, 8'hEE);

    // A: ch0 always enabled, ch1 enabled every other cycle, read-before-write on ch1
    c0 = cyc;
    for (int k = 1; k <= 12; k++) q0.push_back('{d: 8'h0A + 8'((k - 1) % 4), t: c0 + 4 * k});
    q1.push_back('{d: 8'h11, t: c0 + 7});
    q1.push_back('{d: 8'h22, t: c0 + 15});
    q1.push_back('{d: 8'h33, t: c0 + 23});
    q1.push_back('{d: 8'h44, t: c0 + 31});
    q1.push_back('{d: 8'h11, t: c0 + 39});
    q1.push_back('{d: 8'h99, t: c0 + 47});
    a_ch = 1'b1;
    a_addr = 2'd1;
    a_data = 8'h99;
    a_en[0] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      a_en[1] = (i % 2 == 0);
      a_we = (i == 14);
      step(1);
    end
    a_en = '0;
    a_we = 1'b0;
    step(2);

    // B: no wrap, done after the last sample, clr restarts from index 0
    c1 = cyc;
    q2.push_back('{d: 8'h0A, t: c1 + 4});
    q2.push_back('{d: 8'h0B, t: c1 + 8});
    q2.push_back('{d: 8'h0C, t: c1 + 12});
    q2.push_back('{d: 8'h0D, t: c1 + 16});
    b_en = 1'b1;
    step(12);
    chk("B done before last", b_done, 0);
    step(4);
    chk("B done at last", b_done, 1);
    step(24);
    chk("B done held", b_done, 1);
    c2 = cyc;
    b_clr = 1'b1;
    step(1);
    b_clr = 1'b0;
    chk("B done after clr", b_done, 0);
    q2.push_back('{d: 8'h0A, t: c2 + 5});
    q2.push_back('{d: 8'h0B, t: c2 + 9});
    step(8);
    b_en = 1'b0;
    step(2);

    // C: hold mode, overruns saturate, ack coinciding with emission
    c3 = cyc;
    c_en = 1'b1;
    step(4);
    chk("C ready e1", c_rdy, 1);
    chk("C out e1", c_out, 8'h0A);
    chk("C ovr e1", c_ovr, 0);
    step(1);
    chk("C ready hold", c_rdy, 1);
    chk("C out hold", c_out, 8'h0A);
    step(3);
    chk("C out ovr1", c_out, 8'h0B);
    chk("C ovr ovr1", c_ovr, 1);
    chk("C ovr_cnt ovr1", c_oc, 1);
    chk("C ready ovr1", c_rdy, 1);
    step(4);
    chk("C ovr_cnt ovr2", c_oc, 2);
    step(4);
    chk("C ovr_cnt ovr3", c_oc, 3);
    step(8);
    chk("C ovr_cnt sat", c_oc, 3);
    chk("C out ovr5", c_out, 8'h0B);
    c_en = 1'b0;
    step(3);
    chk("C ready en off", c_rdy, 1);
    chk("C out en off", c_out, 8'h0B);
    c_en = 1'b1;
    c_clr = 1'b1;
    step(1);
    c_clr = 1'b0;
    chk("C ready clr", c_rdy, 0);
    chk("C out clr", c_out, 0);
    chk("C ovr clr", c_ovr, 0);
    chk("C ovr_cnt clr", c_oc, 0);
    c4 = cyc;
    step(4);
    chk("C ready post clr", c_rdy, 1);
    chk("C out post clr", c_out, 8'h0A);
    step(3);
    c_ack = 1'b1;
    step(1);
    chk("C ready ack+emit", c_rdy, 1);
    chk("C out ack+emit", c_out, 8'h0B);
    chk("C ovr ack+emit", c_ovr, 0);
    chk("C ovr_cnt ack+emit", c_oc, 0);
    step(1);
    c_ack = 1'b0;
    chk("C ready acked", c_rdy, 0);
    chk("C out acked", c_out, 8'h0B);
    step(7);
    chk("C ovr late", c_ovr, 1);
    chk("C out late", c_out, 8'h0D);
    chk("C ready late", c_rdy, 1);
    if (cyc != c4 + 16) chk("C cycle align", cyc, c4 + 16);

    // Asynchronous reset in mid-cycle, then restart from index 0
    step(1);
    #1 rst_n = 1'b0;
    #1;
    chk("C ready async rst", c_rdy, 0);
    chk("C out async rst", c_out, 0);
    chk("C ovr async rst", c_ovr, 0);
    chk("C ovr_cnt async rst", c_oc, 0);
    step(2);
    rst_n = 1'b1;
    r = cyc;
    step(3);
    chk("C ready before first", c_rdy, 0);
    step(1);
    chk("C ready first after rst", c_rdy, 1);
    chk("C out first after rst", c_out, 8'h0A);
    chk("C ovr first after rst", c_ovr, 0);
    if (cyc != r + 4) chk("C rst cycle align", cyc, r + 4);
    c_en = 1'b0;
    step(2);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    chk("q2 drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/sensor_emu.md
Name: sensor_emu

Overview:
Parametrised multi-channel sensor source for the SoC sensor interface. Each channel replays a loadable sample memory at a fixed cycle period while enabled and presents samples with a ready flag. Pulse mode gives the legacy single-cycle ready; hold mode keeps data until acknowledged and flags overruns. It sits outside top, in place of the inline sensor stimulus, and drives sensor_ready/sensor_out.

Parameters:
NUM_CH, 1, number of independent channels
DATA_W, 32, sample width
DEPTH, 256, samples per channel (power of 2)
PERIOD, 1024, enabled cycles between samples (>=2)
HOLD, 0, 0 = pulse ready, 1 = hold until ack
WRAP, 1, 1 = replay memory cyclically, 0 = stop after last sample
OVR_W, 8, overrun counter width

Ports:
clk  in  1  clock
rst  in  1  reset
sensor_en  in  NUM_CH  per-channel enable
sensor_ack  in  NUM_CH  consumer acknowledge (HOLD=1 only; ignored otherwise)
sensor_clr  in  NUM_CH  synchronous channel restart
load_we  in  1  sample-memory write strobe
load_ch  in  clog2(NUM_CH) max 1  target channel
load_addr  in  clog2(DEPTH)  sample index
load_data  in  DATA_W  sample value
sensor_ready  out  NUM_CH  sample valid
sensor_out  out  NUM_CH*DATA_W  samples; channel k at [k*DATA_W +: DATA_W]
sensor_done  out  NUM_CH  WRAP=0 only: last sample emitted
sensor_ovr  out  NUM_CH  sticky overrun flag
ovr_cnt  out  NUM_CH*OVR_W  saturating overrun counts

Behaviour:
- One clock, clk. rst is asynchronous and active-low.
- Reset: cnt=0, ptr=0, sensor_ready=0, sensor_out=0, sensor_done=0, sensor_ovr=0, ovr_cnt=0. Sample memory is not reset.
- Channels are fully independent. Per channel, cnt counts only while sensor_en=1 and holds when en=0.
- Emission: en=1, cnt==PERIOD-1, and not done. On that edge, cnt goes to 0, sensor_out takes mem[ptr], sensor_ready goes to 1, and ptr increments.
- The first emission after reset or clr appears PERIOD enabled cycles later.
- ptr at DEPTH-1: with WRAP=1 it wraps to 0. With WRAP=0 it sets done on the same edge. While done, cnt freezes and nothing further is emitted until clr.
- HOLD=0: ready is high for exactly the cycle after an emission edge. In all other cycles sensor_out is 0 (never X).
- HOLD=1: ready and data hold until the first edge with sensor_ack=1, which clears ready. sensor_out keeps the last value.
- HOLD=1, emission while ready=1 and ack=0 is an overrun: data is replaced, ready stays 1, sensor_ovr is set, ovr_cnt increments and saturates at all-ones.
- HOLD=1, emission and ack in the same cycle: the ack consumes the old sample. New data is loaded, ready stays 1, no overrun.
- sensor_en deasserted while ready=1 has no effect on ready or data.
- sensor_clr has priority over emission and ack. It sets cnt=0, ptr=0, ready=0, out=0, done=0, ovr=0, ovr_cnt=0. Memory is kept.
- Memory write: load_we writes mem[load_ch][load_addr] on the edge. If the same address is emitted on the same edge, the emitted sample is the old value (read-before-write).
- load_ch >= NUM_CH is ignored.
- Loads are legal at any time, including while the channel is enabled.

Decomposition:
- Package sensor_emu_pkg: mode constants (HOLD_PULSE=0, HOLD_ACK=1), a clog2-based width helper, and the default parameter constants.
- One sub-module, sensor_emu_ch, holds one channel's memory, cnt, ptr, ready/data, done and overrun logic.
- The top generates NUM_CH instances and decodes load_ch.

Test Plan:
1. NUM_CH=1, PERIOD=4, DEPTH=4, HOLD=0, WRAP=1; load 0xA,0xB,0xC,0xD; en=1 continuously -> ready pulses every 4th cycle, one cycle each; out=0xA,0xB,0xC,0xD,0xA; out=0 between pulses.
2. Same config but WRAP=0 -> four pulses, done=1 on the 4th emission edge, no 5th pulse in 20 cycles; clr -> done=0, next pulse is 0xA after 4 cycles.
3. HOLD=1, PERIOD=4; ack is never driven -> 2nd emission gives ovr=1, ovr_cnt=1, out=0xB, ready stays 1; with OVR_W=2, after 5 overruns ovr_cnt=3.
4. HOLD=1; ack asserted exactly on an emission cycle -> ready stays 1, new data loaded, ovr=0; ack one cycle later -> ready=0.
5. NUM_CH=2; channel 0 en=1, channel 1 en toggled 1/0 -> channel 1 emits at half the rate, channel 0 unaffected; load_ch=1 writing the address being emitted that cycle -> old value emitted.
6. Assert rst mid-period with ready=1 and ovr=1 -> all outputs 0 immediately (asynchronous); after release, the first pulse is PERIOD enabled cycles later with sample index 0.
